param_matrix_scanner: RTL and testbench
=======================================

Name: param_matrix_scanner

Overview:
Parametrised successor to the fixed 8x8 chessboard sensor scanner. Drives an external row decoder, samples active-low column sensors after a programmable settle time, and debounces each square over consecutive scans. Publishes the debounced occupancy bitmap and a valid/ready stream of per-square change events, which downstream move-detection logic consumes instead of diffing full bitmaps.

Parameters:
ROWS, 8, number of matrix rows (2..16)
COLS, 8, number of column inputs (1..16)
ROW_AW, 3, row address width; must satisfy 2**ROW_AW >= ROWS
SETTLE_CYCLES, 16, cycles the row is driven before sampling; minimum 3, to cover the 2-flop synchroniser
DEBOUNCE_SCANS, 4, consecutive differing scans needed to flip a square (1 = no debounce)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
scan_en  in  1  level; 1 = scan continuously, 0 = stop after the current row
col_in  in  COLS  raw column sensors, active-low, asynchronous
row_addr  out  ROW_AW  row address to the external decoder
row_addr_en  out  1  decoder enable, active-low
sensor_state  out  ROWS*COLS  debounced occupancy; bit r*COLS+c; 1 = piece present
scan_busy  out  1  1 when FSM is not IDLE
frame_done  out  1  one-cycle pulse at the end of each complete frame
change_valid  out  1  change event available
change_ready  in  1  consumer accepts the event
change_square  out  $clog2(ROWS*COLS)  index of the changed square
change_level  out  1  new debounced value of that square

Behaviour:
- Reset values: row_addr=0, row_addr_en=1, sensor_state=0, scan_busy=0, frame_done=0, change_valid=0, change_square=0, change_level=0. All debounce counters, pending bits, and synchroniser flops are cleared. Reset mid-row returns to IDLE immediately, with row_addr_en=1 on the next cycle.
- col_in passes through a 2-flop synchroniser. The inverted synchronised value is raw (1 = present).
- FSM states: IDLE, DRIVE, BLANK.
- IDLE: row_addr_en=1. If scan_en=1, go to DRIVE with row_addr=0 and settle counter=0.
- DRIVE: row_addr_en=0, counting for SETTLE_CYCLES cycles. On the last cycle (count=SETTLE_CYCLES-1), sample raw for the current row, then go to BLANK.
- BLANK: one cycle with row_addr_en=1; row_addr advances here. If the row was ROWS-1, row_addr wraps to 0 and frame_done=1 for this cycle.
- Leaving BLANK: if scan_en=1, go to DRIVE; otherwise go to IDLE with row_addr=0.
- scan_en dropping during DRIVE does not abort the row.
- Timing: a row takes SETTLE_CYCLES+1 cycles; a frame takes ROWS*(SETTLE_CYCLES+1) cycles.
- Debounce, per square, updated only at the sample cycle of its row:
  - raw==stable: counter <= 0.
  - raw!=stable and counter==DEBOUNCE_SCANS-1: stable <= raw, counter <= 0, pending bit set.
  - Otherwise: counter +1.
  - sensor_state reflects the new stable value on the cycle after the sample.
- Change stream: a single output holding register.
  - Load condition: register empty (change_valid=0) or handshaking (change_valid & change_ready), and any pending bit set.
  - On load: take the lowest-index pending square, capture its current stable value into change_level, clear its pending bit, and set change_valid next cycle.
  - change_square and change_level are stable while change_valid=1 and change_ready=0.
  - Set and clear of the same pending bit in one cycle: set wins.
  - A square that changes again after being loaded is re-pended and reported again. Events are never dropped; the pending bitmap saturates per square.
  - Throughput: one event per cycle.

Optional Feature:
FRAME_COUNT_EN: when defined, adds output port frame_count [15:0].
- Reset value is 0; increments on every frame_done pulse and wraps from 0xFFFF to 0.
- When undefined, the port and counter are absent and all other behaviour is identical.

Test Plan:
- ROWS=8, COLS=8, SETTLE_CYCLES=4, col_in=8'hFF, scan_en=1 from cycle 0 after reset:
  - row_addr steps 0..7, each with row_addr_en low for 4 cycles then high for 1 cycle.
  - frame_done pulses every 40 cycles; sensor_state stays 0 and change_valid never asserts.
- DEBOUNCE_SCANS=3, hold col_in[2]=0 while row 5 is driven:
  - Bit 42 of sensor_state sets after the 3rd frame's row-5 sample.
  - Event change_square=42, change_level=1 is accepted with change_ready=1.
- Glitch col_in[2]=0 for exactly 2 consecutive row-5 scans, then release:
  - sensor_state bit 42 never sets; no event is emitted.
- Squares 3 and 17 flip in the same frame with change_ready=0:
  - change_valid holds square 3 stable for 10 cycles.
  - After ready rises, square 3 then square 17 are delivered on consecutive cycles.
- Deassert scan_en mid-DRIVE of row 2:
  - Row 2 completes, BLANK follows, then IDLE with row_addr=0 and scan_busy=0.
  - Assert rst during DRIVE of row 4: next cycle row_addr_en=1, sensor_state=0, change_valid=0.
- FRAME_COUNT_EN defined, 65537 frames:
  - frame_count reads 1 after wrap.

Source files
------------

// File: rtl/param_matrix_scanner.sv
// Row-by-row sensor matrix scanner with per-square debounce and a valid/ready change-event stream.
// Optional: define FRAME_COUNT_EN to add a 16-bit wrapping frame counter output.
`timescale 1ns / 1ps

module param_matrix_scanner #(
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 8,
    parameter int unsigned ROW_AW         = 3,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         scan_en,
    input  logic [COLS-1:0]              col_in,
    output logic [ROW_AW-1:0]            row_addr,
    output logic                         row_addr_en,
    output logic [ROWS*COLS-1:0]         sensor_state,
    output logic                         scan_busy,
    output logic                         frame_done,
`ifdef FRAME_COUNT_EN
    output logic [15:0]                  frame_count,
`endif
    output logic                         change_valid,
    input  logic                         change_ready,
    output logic [$clog2(ROWS*COLS)-1:0] change_square,
    output logic                         change_level
);

    localparam int unsigned NumSq = ROWS * COLS;
    localparam int unsigned SqW   = $clog2(NumSq);
    localparam int unsigned SetW  = $clog2(SETTLE_CYCLES);
    localparam int unsigned CntW  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

    typedef enum logic [1:0] {StIdle, StDrive, StBlank} state_e;

    state_e            state_q, state_d;
    logic [ROW_AW-1:0] row_q, row_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic [COLS-1:0]   col_meta_q, col_sync_q, raw;
    logic [NumSq-1:0]  stable_q, stable_d, pend_q, pend_d, pend_set, pend_clr;
    logic [CntW-1:0]   cnt_q [NumSq];
    logic [CntW-1:0]   cnt_d [NumSq];
    logic              valid_q, valid_d, level_q, level_d, sample, load;
    logic [SqW-1:0]    sq_q, sq_d, sel;

    assign raw = ~col_sync_q;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q;
        sample   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (scan_en) begin
                    state_d  = StDrive;
                    row_d    = '0;
                    settle_d = '0;
                end
            end
            StDrive: begin
                if (settle_q == SetW'(SETTLE_CYCLES - 1)) begin
                    sample  = 1'b1;
                    state_d = StBlank;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StBlank: begin
                settle_d = '0;
                if (scan_en) begin
                    state_d = StDrive;
                    row_d   = (row_q == ROW_AW'(ROWS - 1)) ? '0 : row_q + 1'b1;
                end else begin
                    state_d = StIdle;
                    row_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Only squares of the row being sampled move their debounce state.
    always_comb begin
        stable_d = stable_q;
        pend_set = '0;
        for (int i = 0; i < int'(NumSq); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sample && (ROW_AW'(i / int'(COLS)) == row_q)) begin
                if (raw[i % int'(COLS)] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CntW'(DEBOUNCE_SCANS - 1)) begin
                    stable_d[i] = raw[i % int'(COLS)];
                    cnt_d[i]    = '0;
                    pend_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Lowest pending index wins; a fresh set of the same bit overrides its clear.
    always_comb begin
        sel      = '0;
        pend_clr = '0;
        valid_d  = valid_q;
        sq_d     = sq_q;
        level_d  = level_q;
        for (int i = int'(NumSq) - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = SqW'(i);
        end
        load = (!valid_q || change_ready) && (|pend_q);
        if (load) begin
            valid_d       = 1'b1;
            sq_d          = sel;
            level_d       = stable_q[sel];
            pend_clr[sel] = 1'b1;
        end else if (change_ready) begin
            valid_d = 1'b0;
        end
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            row_q      <= '0;
            settle_q   <= '0;
            col_meta_q <= '0;
            col_sync_q <= '0;
            stable_q   <= '0;
            pend_q     <= '0;
            valid_q    <= 1'b0;
            sq_q       <= '0;
            level_q    <= 1'b0;
            for (int i = 0; i < int'(NumSq); i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            settle_q   <= settle_d;
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
            stable_q   <= stable_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
            sq_q       <= sq_d;
            level_q    <= level_d;
            for (int i = 0; i < int'(NumSq); i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef FRAME_COUNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (frame_done) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_count = frame_cnt_q;
`endif

    assign row_addr      = row_q;
    assign row_addr_en   = (state_q != StDrive);
    assign sensor_state  = stable_q;
    assign scan_busy     = (state_q != StIdle);
    assign frame_done    = (state_q == StBlank) && (row_q == ROW_AW'(ROWS - 1));
    assign change_valid  = valid_q;
    assign change_square = sq_q;
    assign change_level  = level_q;

endmodule

// File: tb/tb_param_matrix_scanner.sv
// Bench for param_matrix_scanner: emulates an 8x8 board behind the row decoder and checks against
// a row-level debounce model and an outstanding-event list.
`timescale 1ns / 1ps

module tb_param_matrix_scanner;

    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int ROW_AW = 3;
    localparam int SETTLE = 4;
    localparam int DB     = 3;
    localparam int NSQ    = ROWS * COLS;

    logic              clk = 1'b0;
    logic              rst;
    logic              scan_en;
    logic [COLS-1:0]   col_in;
    logic [ROW_AW-1:0] row_addr;
    logic              row_addr_en;
    logic [NSQ-1:0]    sensor_state;
    logic              scan_busy;
    logic              frame_done;
    logic              change_valid;
    logic              change_ready;
    logic [5:0]        change_square;
    logic              change_level;
`ifdef FRAME_COUNT_EN
    logic [15:0]       frame_count;
`endif

    param_matrix_scanner #(
        .ROWS           (ROWS),
        .COLS           (COLS),
        .ROW_AW         (ROW_AW),
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .scan_en       (scan_en),
        .col_in        (col_in),
        .row_addr      (row_addr),
        .row_addr_en   (row_addr_en),
        .sensor_state  (sensor_state),
        .scan_busy     (scan_busy),
        .frame_done    (frame_done),
`ifdef FRAME_COUNT_EN
        .frame_count   (frame_count),
`endif
        .change_valid  (change_valid),
        .change_ready  (change_ready),
        .change_square (change_square),
        .change_level  (change_level)
    );

    always #5 clk = ~clk;

    // Pieces present on the board; only the driven row reaches the active-low columns.
    logic [NSQ-1:0] board;
    always_comb begin
        col_in = '1;
        if (!row_addr_en) col_in = ~board[int'(row_addr) * COLS +: COLS];
    end

    int total, bad;
    int cyc, rr, drive_len, last_fd, ready_mode;
    bit prev_en, fd_seen, fd_prev;
    int fc_exp;
    bit stable_m [NSQ];
    int cnt_m [NSQ];
    int exp_evt [$];  // square*2 + level
    int log_sq [$];
    int log_lvl [$];
    int log_cyc [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NSQ-1:0] model_vec();
        logic [NSQ-1:0] v;
        for (int i = 0; i < NSQ; i++) v[i] = stable_m[i];
        return v;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < NSQ; i++) begin
            stable_m[i] = 1'b0;
            cnt_m[i]    = 0;
        end
        exp_evt.delete();
        rr = 0;
        drive_len = 0;
        last_fd = 0;
        prev_en = 1'b1;
        fc_exp = 0;
        fd_prev = 1'b0;
    endtask

    task automatic model_row(input int r);
        for (int c = 0; c < COLS; c++) begin
            int i;
            i = r * COLS + c;
            if (board[i] == stable_m[i]) begin
                cnt_m[i] = 0;
            end else if (cnt_m[i] == DB - 1) begin
                stable_m[i] = board[i];
                cnt_m[i] = 0;
                exp_evt.push_back(i * 2 + int'(board[i]));
            end else begin
                cnt_m[i]++;
            end
        end
    endtask

    task automatic accept_event();
        int k;
        k = -1;
        log_sq.push_back(int'(change_square));
        log_lvl.push_back(int'(change_level));
        log_cyc.push_back(cyc);
        for (int j = 0; j < exp_evt.size(); j++) begin
            if (k < 0 && exp_evt[j] / 2 == int'(change_square)) k = j;
        end
        check_eq("evt_known", 64'(k >= 0), 64'd1);
        if (k >= 0) begin
            check_eq("evt_level", 64'(change_level), 64'(exp_evt[k] % 2));
            exp_evt.delete(k);
        end
    endtask

    task automatic tick();
        bit blank;
        @(negedge clk);
        cyc++;
        case (ready_mode)
            0: change_ready = ($urandom_range(0, 3) != 0);
            1: change_ready = 1'b1;
            default: change_ready = 1'b0;
        endcase
        if (rst) begin
            prev_en = 1'b1;
            return;
        end
`ifdef FRAME_COUNT_EN
        if (fd_prev) check_eq("frame_count", 64'(frame_count), 64'(fc_exp % 65536));
`endif
        fd_prev = 1'b0;
        blank = row_addr_en && !prev_en;
        if (!row_addr_en) begin
            drive_len++;
        end else if (blank) begin
            check_eq("drive_len", 64'(drive_len), 64'(SETTLE));
            check_eq("row_addr", 64'(row_addr), 64'(rr));
            model_row(rr);
            check_eq("sensor_state", 64'(sensor_state), 64'(model_vec()));
            check_eq("frame_done", 64'(frame_done), 64'(rr == ROWS - 1));
            if (frame_done) begin
                if (last_fd > 0) check_eq("frame_period", 64'(cyc - last_fd), 64'(ROWS * (SETTLE + 1)));
                last_fd = cyc;
                fd_seen = 1'b1;
                fc_exp++;
                fd_prev = 1'b1;
            end
            rr = (rr + 1) % ROWS;
            drive_len = 0;
        end else if (!scan_busy) begin
            rr = 0;
            drive_len = 0;
            last_fd = 0;
        end
        if (frame_done && !blank) check_eq("fd_spurious", 64'(frame_done), 64'd0);
        if (change_valid && change_ready) accept_event();
        prev_en = row_addr_en;
    endtask

    task automatic wait_frames(input int n);
        for (int f = 0; f < n; f++) begin
            int c;
            c = 0;
            fd_seen = 1'b0;
            while (!fd_seen && c < 200) begin
                tick();
                c++;
            end
            check_eq("frame_wait", 64'(fd_seen), 64'd1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        scan_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        reset_model();
    endtask

    task automatic find_drive_row(input int r);
        int k;
        k = 0;
        while (!(int'(row_addr) == r && !row_addr_en) && k < 200) begin
            tick();
            k++;
        end
        check_eq("row_found", 64'(int'(row_addr) == r && !row_addr_en), 64'd1);
    endtask

    initial begin
        int n0, k;
        total = 0;
        bad = 0;
        cyc = 0;
        board = '0;
        ready_mode = 2;
        change_ready = 1'b0;
        reset_model();
        do_reset();
        rst = 1'b1;
        tick();
        check_eq("rst_row_addr", 64'(row_addr), 64'd0);
        check_eq("rst_row_en", 64'(row_addr_en), 64'd1);
        check_eq("rst_sensor", 64'(sensor_state), 64'd0);
        check_eq("rst_busy", 64'(scan_busy), 64'd0);
        check_eq("rst_fd", 64'(frame_done), 64'd0);
        check_eq("rst_valid", 64'(change_valid), 64'd0);
        check_eq("rst_square", 64'(change_square), 64'd0);
        check_eq("rst_level", 64'(change_level), 64'd0);
        rst = 1'b0;
        reset_model();

        // Empty board: frames tick over, nothing changes.
        ready_mode = 1;
        scan_en = 1'b1;
        wait_frames(2);
        check_eq("empty_no_evt", 64'(log_sq.size()), 64'd0);

        // Square 42 (row 5, col 2) held: flips on the third sample.
        board[42] = 1'b1;
        wait_frames(2);
        check_eq("sq42_after2", 64'(sensor_state[42]), 64'd0);
        wait_frames(1);
        check_eq("sq42_after3", 64'(sensor_state[42]), 64'd1);
        check_eq("sq42_evt_n", 64'(log_sq.size()), 64'd1);
        if (log_sq.size() == 1) begin
            check_eq("sq42_evt_sq", 64'(log_sq[0]), 64'd42);
            check_eq("sq42_evt_lvl", 64'(log_lvl[0]), 64'd1);
        end
        board[42] = 1'b0;
        wait_frames(3);
        check_eq("sq42_clear", 64'(sensor_state[42]), 64'd0);

        // Two-scan glitch must be filtered out.
        n0 = log_sq.size();
        board[42] = 1'b1;
        wait_frames(2);
        board[42] = 1'b0;
        wait_frames(3);
        check_eq("glitch_no_evt", 64'(log_sq.size()), 64'(n0));
        check_eq("glitch_state", 64'(sensor_state[42]), 64'd0);

        // Random board churn with a sluggish consumer.
        ready_mode = 0;
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(1, 3)) begin
                k = $urandom_range(0, NSQ - 1);
                board[k] = ~board[k];
            end
            wait_frames(1);
        end
        ready_mode = 1;
        wait_frames(4);
        check_eq("rand_drained", 64'(exp_evt.size()), 64'd0);

        // Squares 3 and 17 flip in one frame while the consumer stalls.
        do_reset();
        board = '0;
        board[3] = 1'b1;
        board[17] = 1'b1;
        ready_mode = 2;
        scan_en = 1'b1;
        wait_frames(3);
        for (int t = 0; t < 10; t++) begin
            check_eq("hold_valid", 64'(change_valid), 64'd1);
            check_eq("hold_square", 64'(change_square), 64'd3);
            check_eq("hold_level", 64'(change_level), 64'd1);
            tick();
        end
        n0 = log_sq.size();
        ready_mode = 1;
        repeat (3) tick();
        check_eq("pair_n", 64'(log_sq.size()), 64'(n0 + 2));
        if (log_sq.size() >= n0 + 2) begin
            check_eq("pair_first", 64'(log_sq[n0]), 64'd3);
            check_eq("pair_second", 64'(log_sq[n0 + 1]), 64'd17);
            check_eq("pair_gap", 64'(log_cyc[n0 + 1] - log_cyc[n0]), 64'd1);
        end

        // scan_en drops in the middle of row 2: the row still completes.
        find_drive_row(2);
        tick();
        scan_en = 1'b0;
        k = 0;
        while (!row_addr_en && k < 20) begin
            tick();
            k++;
        end
        check_eq("stop_blank_row", 64'(row_addr), 64'd2);
        check_eq("stop_blank_busy", 64'(scan_busy), 64'd1);
        tick();
        check_eq("stop_idle_busy", 64'(scan_busy), 64'd0);
        check_eq("stop_idle_row", 64'(row_addr), 64'd0);
        check_eq("stop_idle_en", 64'(row_addr_en), 64'd1);
        repeat (5) tick();
        check_eq("stop_stays_idle", 64'(scan_busy), 64'd0);

        // Restart, light up square 0, then reset in the middle of row 4.
        board[0] = 1'b1;
        scan_en = 1'b1;
        wait_frames(3);
        check_eq("sq0_set", 64'(sensor_state[0]), 64'd1);
        find_drive_row(4);
        tick();
        rst = 1'b1;
        tick();
        check_eq("midrst_en", 64'(row_addr_en), 64'd1);
        check_eq("midrst_sensor", 64'(sensor_state), 64'd0);
        check_eq("midrst_valid", 64'(change_valid), 64'd0);
        check_eq("midrst_busy", 64'(scan_busy), 64'd0);
        check_eq("midrst_row", 64'(row_addr), 64'd0);
        rst = 1'b0;
        scan_en = 1'b0;
        reset_model();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
